// File: rtl/loader_pkg.sv
// Shared constants for the serial program loader.
// Loader state encodings, frame sync byte and counter widths.
package loader_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_CNT_LO = 3'd1;
    localparam state_t S_CNT_HI = 3'd2;
    localparam state_t S_DATA   = 3'd3;
    localparam state_t S_CHECK  = 3'd4;
    localparam state_t S_DONE   = 3'd5;
    localparam state_t S_ERR    = 3'd6;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam int WCNT_W = 16;
    localparam int BCNT_W = 2;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with 2-flop synchroniser.
// Emits a 1-cycle byte_valid or frame_err after the stop-bit sample.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    logic [2:0]    sync;
    logic [1:0]    rstate;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          rx_s;
    logic          fall;

    assign rx_s = sync[1];
    assign fall = sync[2] & ~sync[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync       <= 3'b111;
            rstate     <= R_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync       <= {sync[1:0], rx};
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (rstate)
                R_IDLE: begin
                    if (fall) begin
                        rstate <= R_START;
                        cnt    <= '0;
                    end
                end
                R_START: begin
                    if (cnt == HALF) begin
                        // high at mid-start means the edge was a glitch
                        cnt     <= '0;
                        bit_idx <= '0;
                        rstate  <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == FULL) begin
                        cnt       <= '0;
                        byte_data <= {rx_s, byte_data[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rstate <= R_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == FULL) begin
                        cnt        <= '0;
                        rstate     <= R_IDLE;
                        byte_valid <= rx_s;
                        frame_err  <= ~rx_s;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed UART program loader driving the instruction-memory write port.
// Holds the core in reset until a checksum-verified image is loaded.
module imem_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int MW = WCNT_W + 1;
    localparam logic [MW-1:0] MAX_WORDS = MW'(1) << ADDR_W;

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              frame_err;
    state_t            state;
    logic [WCNT_W-1:0] n_words;
    logic [WCNT_W-1:0] word_cnt;
    logic [BCNT_W-1:0] byte_cnt;
    logic [31:0]       shreg;
    logic [7:0]        chk;
    logic [WCNT_W-1:0] n_next;
    logic [31:0]       word_next;
    logic              idle_like;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    assign n_next    = {byte_data, n_words[7:0]};
    assign word_next = {byte_data, shreg[31:8]};
    assign idle_like = (state == S_IDLE) || (state == S_DONE) ||
                       (state == S_ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            n_words    <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            shreg      <= '0;
            chk        <= '0;
        end else begin
            imem_we <= 1'b0;
            if (imem_we) imem_addr <= imem_addr + ADDR_W'(1);
            if (frame_err && !idle_like) begin
                state <= S_ERR;
                err   <= 1'b1;
                busy  <= 1'b0;
            end else if (byte_valid) begin
                unique case (1'b1)
                    idle_like: begin
                        if (byte_data == SYNC_BYTE) begin
                            state     <= S_CNT_LO;
                            done      <= 1'b0;
                            err       <= 1'b0;
                            busy      <= 1'b1;
                            cpu_hold  <= 1'b1;
                            chk       <= '0;
                            imem_addr <= '0;
                            word_cnt  <= '0;
                            byte_cnt  <= '0;
                        end
                    end
                    (state == S_CNT_LO): begin
                        n_words[7:0] <= byte_data;
                        chk          <= chk ^ byte_data;
                        state        <= S_CNT_HI;
                    end
                    (state == S_CNT_HI): begin
                        n_words <= n_next;
                        chk     <= chk ^ byte_data;
                        if ({1'b0, n_next} > MAX_WORDS) begin
                            state <= S_ERR;
                            err   <= 1'b1;
                            busy  <= 1'b0;
                        end else if (n_next == '0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    (state == S_DATA): begin
                        shreg    <= word_next;
                        chk      <= chk ^ byte_data;
                        byte_cnt <= byte_cnt + BCNT_W'(1);
                        if (byte_cnt == '1) begin
                            imem_we    <= 1'b1;
                            imem_wdata <= word_next;
                            word_cnt   <= word_cnt + WCNT_W'(1);
                            if (word_cnt + WCNT_W'(1) == n_words)
                                state <= S_CHECK;
                        end
                    end
                    (state == S_CHECK): begin
                        busy <= 1'b0;
                        if (byte_data == chk) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            err   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader with CLKS_PER_BIT=16, ADDR_W=4.
// Expected writes are queued by the stimulus and checked by a monitor.
module tb_imem_loader;

    localparam int CPB = 16;
    localparam int AW  = 4;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;
    typedef logic [7:0] bq_t[$];

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx  = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold, busy, done, err;

    wr_t exp_q[$];
    int  tests  = 0;
    int  fails  = 0;
    int  bv_cnt = 0;
    logic prev_we = 1'b0;

    imem_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (dut.u_rx.byte_valid) bv_cnt++;
        if (rst && imem_we) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: got addr %h data %h expected none",
                         imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.a));
                check("wr_data", imem_wdata, e.d);
            end
            check("we_pulse_width", 32'(prev_we), 32'd0);
        end
        prev_we <= rst && imem_we;
    end

    task automatic send_byte(input logic [7:0] b, input logic bad_stop);
        @(negedge clk) rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = ~bad_stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_bytes(input bq_t bs);
        foreach (bs[i]) send_byte(bs[i], 1'b0);
    endtask

    task automatic check_status(input string tag, input logic h,
                                input logic b, input logic d, input logic e);
        @(negedge clk);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
        check({tag, "_busy"}, 32'(busy), 32'(b));
        check({tag, "_done"}, 32'(done), 32'(d));
        check({tag, "_err"}, 32'(err), 32'(e));
    endtask

    task automatic check_reset_vals(input string tag);
        check_status(tag, 1'b1, 1'b0, 1'b0, 1'b0);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
    endtask

    task automatic push_two_words();
        exp_q.push_back('{a: 4'd0, d: 32'h0000_0013});
        exp_q.push_back('{a: 4'd1, d: 32'h0010_0093});
    endtask

    initial begin
        int bv0;
        repeat (5) @(negedge clk);
        check_reset_vals("in_reset");
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_reset_vals("after_reset");

        bv0 = bv_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        check("glitch_no_byte", 32'(bv_cnt - bv0), 32'd0);
        check_status("glitch", 1'b1, 1'b0, 1'b0, 1'b0);

        push_two_words();
        send_byte(8'hA5, 1'b0);
        check_status("sync", 1'b1, 1'b1, 1'b0, 1'b0);
        send_bytes('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'h93, 8'h00, 8'h10, 8'h00, 8'h92});
        check_status("good", 1'b0, 1'b0, 1'b1, 1'b0);
        check("good_addr_end", 32'(imem_addr), 32'd2);

        push_two_words();
        send_byte(8'hA5, 1'b0);
        check_status("sync2", 1'b1, 1'b1, 1'b0, 1'b0);
        send_bytes('{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'h93, 8'h00, 8'h10, 8'h00, 8'h83});
        check_status("bad_chk", 1'b1, 1'b0, 1'b0, 1'b1);

        send_bytes('{8'hA5, 8'h11, 8'h00});
        check_status("too_long", 1'b1, 1'b0, 1'b0, 1'b1);

        send_bytes('{8'hA5, 8'h01, 8'h00, 8'h13});
        send_byte(8'h00, 1'b1);
        check_status("frame_err", 1'b1, 1'b0, 1'b0, 1'b1);
        send_bytes('{8'hA5, 8'h00, 8'h00, 8'h00});
        check_status("empty_img", 1'b0, 1'b0, 1'b1, 1'b0);

        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00});
        @(negedge clk) rst = 1'b0;
        check_reset_vals("mid_reset");
        rst = 1'b1;
        repeat (4 * CPB) @(negedge clk);
        push_two_words();
        send_bytes('{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                     8'h93, 8'h00, 8'h10, 8'h00, 8'h92});
        check_status("reload", 1'b0, 1'b0, 1'b1, 1'b0);

        check("writes_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
